// File: rtl/ifu_pkg.sv
// Shared fetch-stage definitions: default widths, the reset PC,
// FSM state encodings and AXI response codes.
package ifu_pkg;

   localparam int          CPU_WIDTH = 32;
   localparam int          INS_WIDTH = 32;
   localparam logic [31:0] RESET_PC  = 32'h8000_0000;

   // Fetch FSM encodings
   localparam logic [1:0] IFU_IDLE = 2'd0;
   localparam logic [1:0] IFU_REQ  = 2'd1;
   localparam logic [1:0] IFU_WAIT = 2'd2;

   // AXI read response codes
   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_SLVERR = 2'b10;
   localparam logic [1:0] AXI_DECERR = 2'b11;

   // Any response other than OKAY is an access fault for fetch.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != AXI_OKAY;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO for fetched instructions. Flush empties it in
// one cycle; the read port holds the last presented entry while empty
// so downstream never sees undefined data.
module ifu_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] last_q;
   logic             do_push;
   logic             do_pop;

   assign o_empty = (count == '0);
   assign o_full  = (count == CW'(DEPTH));
   assign o_count = count;
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;
   assign o_rdata = o_empty ? last_q : mem[rd_ptr];

   // Storage write; contents only matter while counted as valid
   always_ff @(posedge i_clk) begin
      if (do_push && !i_flush) mem[wr_ptr] <= i_wdata;
   end

   // Pointer and occupancy tracking; flush wins over push/pop
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Remember the presented entry so the output holds once drained
   always_ff @(posedge i_clk) begin
      if (i_rst) last_q <= '0;
      else       last_q <= o_rdata;
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one AXI-lite read at a time,
// buffers responses and hands them to decode. Redirects flush the
// buffer and mark any in-flight response as stale.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int                   CPU_WIDTH  = ifu_pkg::CPU_WIDTH,
   parameter int                   INS_WIDTH  = ifu_pkg::INS_WIDTH,
   parameter logic [CPU_WIDTH-1:0] RESET_PC   = CPU_WIDTH'(ifu_pkg::RESET_PC),
   parameter int                   FIFO_DEPTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_redirect,
   input  logic [CPU_WIDTH-1:0] i_redirect_pc,
   output logic                 o_ifu_arvalid,
   output logic [CPU_WIDTH-1:0] o_ifu_araddr,
   input  logic                 i_ifu_arready,
   input  logic                 i_ifu_rvalid,
   input  logic [INS_WIDTH-1:0] i_ifu_rdata,
   input  logic [1:0]           i_ifu_rresp,
   output logic                 o_ifu_rready,
   output logic [INS_WIDTH-1:0] o_instr,
   output logic [CPU_WIDTH-1:0] o_pc,
   output logic                 o_acc_fault,
   output logic                 o_post_valid,
   input  logic                 i_post_ready
);

   localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int               ENT_W   = INS_WIDTH + CPU_WIDTH + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [CPU_WIDTH-1:0] fetch_pc;
   logic [CPU_WIDTH-1:0] req_pc;
   logic                 drop;
   logic                 ar_hs;
   logic                 r_hs;
   logic                 rd_err;
   logic [INS_WIDTH-1:0] rd_ins;
   logic                 push;
   logic                 pop;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [CNT_W-1:0]     fifo_cnt;
   logic [ENT_W-1:0]     push_ent;
   logic [ENT_W-1:0]     head_ent;

   assign ar_hs  = (state == IFU_REQ)  && i_ifu_arready;
   assign r_hs   = (state == IFU_WAIT) && i_ifu_rvalid;
   assign rd_err = resp_is_err(i_ifu_rresp);
   assign rd_ins = rd_err ? '0 : i_ifu_rdata;

   // A response is kept only if no redirect made it stale
   assign push     = r_hs && !drop && !i_redirect;
   assign push_ent = {rd_ins, req_pc, rd_err};

   // Decode must not see an entry in the cycle it is being flushed
   assign o_post_valid = !fifo_empty && !i_redirect;
   assign pop          = o_post_valid && i_post_ready;
   assign {o_instr, o_pc, o_acc_fault} = head_ent;

   // req_pc is the address of the current/last request, so araddr stays
   // stable through a redirect until the handshake completes
   assign o_ifu_arvalid = (state == IFU_REQ);
   assign o_ifu_araddr  = req_pc;
   assign o_ifu_rready  = (state != IFU_IDLE);

   // Next-state logic; in IDLE nothing is outstanding, so the credit
   // check reduces to free FIFO space
   always_comb begin
      state_nxt = state;
      case (state)
         IFU_IDLE: if (!i_redirect && (fifo_cnt < DEPTH_C)) state_nxt = IFU_REQ;
         IFU_REQ:  if (i_ifu_arready) state_nxt = IFU_WAIT;
         IFU_WAIT: if (i_ifu_rvalid)  state_nxt = IFU_IDLE;
         default:  state_nxt = IFU_IDLE;
      endcase
   end

   // FSM state and captured request address
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IFU_IDLE;
         req_pc <= {RESET_PC[CPU_WIDTH-1:2], 2'b00};
      end else begin
         state <= state_nxt;
         if (state == IFU_IDLE && state_nxt == IFU_REQ) req_pc <= fetch_pc;
      end
   end

   // Fetch PC: redirect wins; a stale (dropped) request does not advance it
   always_ff @(posedge i_clk) begin
      if (i_rst)                fetch_pc <= {RESET_PC[CPU_WIDTH-1:2], 2'b00};
      else if (i_redirect)      fetch_pc <= {i_redirect_pc[CPU_WIDTH-1:2], 2'b00};
      else if (ar_hs && !drop)  fetch_pc <= fetch_pc + CPU_WIDTH'(4);
   end

   // Drop flag: set when a redirect leaves a response still to come,
   // cleared once exactly one response has been consumed
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         drop <= 1'b0;
      end else if (i_redirect) begin
         case (state)
            IFU_REQ:  drop <= 1'b1;
            IFU_WAIT: drop <= !i_ifu_rvalid;
            default:  drop <= drop;
         endcase
      end else if (r_hs) begin
         drop <= 1'b0;
      end
   end

   ifu_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_redirect),
      .i_push  (push),
      .i_wdata (push_ent),
      .i_pop   (pop),
      .o_rdata (head_ent),
      .o_empty (fifo_empty),
      .o_full  (fifo_full),
      .o_count (fifo_cnt)
   );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a simple single-beat memory model.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] XMASK  = 32'hA5A5_0000;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_ifu_arvalid;
   logic [31:0] o_ifu_araddr;
   logic        i_ifu_arready;
   logic        i_ifu_rvalid;
   logic [31:0] i_ifu_rdata;
   logic [1:0]  i_ifu_rresp;
   logic        o_ifu_rready;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_acc_fault;
   logic        o_post_valid;
   logic        i_post_ready;

   ifu_fetch dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_ifu_arvalid (o_ifu_arvalid),
      .o_ifu_araddr  (o_ifu_araddr),
      .i_ifu_arready (i_ifu_arready),
      .i_ifu_rvalid  (i_ifu_rvalid),
      .i_ifu_rdata   (i_ifu_rdata),
      .i_ifu_rresp   (i_ifu_rresp),
      .o_ifu_rready  (o_ifu_rready),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .o_acc_fault   (o_acc_fault),
      .o_post_valid  (o_post_valid),
      .i_post_ready  (i_post_ready)
   );

   always #5 i_clk = ~i_clk;

   int          nvec = 0;
   int          nerr = 0;
   int          lat = 1;
   int          cnt = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic [31:0] ar_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_ins_q[$];
   logic        pop_flt_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: log handshakes seen this cycle, advance, update memory
   task automatic cyc();
      logic        hs;
      logic        rt;
      logic [31:0] a;
      #1;
      hs = o_ifu_arvalid && i_ifu_arready;
      rt = i_ifu_rvalid && o_ifu_rready;
      a  = o_ifu_araddr;
      if (hs) ar_q.push_back(a);
      if (o_post_valid && i_post_ready) begin
         pop_pc_q.push_back(o_pc);
         pop_ins_q.push_back(o_instr);
         pop_flt_q.push_back(o_acc_fault);
      end
      @(posedge i_clk);
      #1;
      if (rt) i_ifu_rvalid = 1'b0;
      if (hs) begin
         pend = 1'b1; pend_addr = a; cnt = lat;
      end
      if (pend && !i_ifu_rvalid) begin
         cnt--;
         if (cnt <= 0) begin
            i_ifu_rvalid = 1'b1;
            i_ifu_rdata  = pend_addr ^ XMASK;
            i_ifu_rresp  = (pend_addr == err_addr) ? 2'b10 : 2'b00;
            pend = 1'b0;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_redirect = 1'b0; i_ifu_rvalid = 1'b0;
      i_ifu_arready = 1'b1; pend = 1'b0;
      run(2);
      ar_q.delete(); pop_pc_q.delete(); pop_ins_q.delete(); pop_flt_q.delete();
   endtask

   // Release reset; returns in the first post-reset REQ cycle
   task automatic rel();
      i_rst = 1'b0;
      cyc();
   endtask

   initial begin
      i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
      i_ifu_arready = 1'b1; i_ifu_rvalid = 1'b0; i_ifu_rdata = '0;
      i_ifu_rresp = 2'b00; i_post_ready = 1'b1;

      // Reset state and in-order streaming
      do_reset();
      chk("rst_arvalid", o_ifu_arvalid, 0);
      chk("rst_araddr", o_ifu_araddr, RST_PC);
      chk("rst_pvalid", o_post_valid, 0);
      chk("rst_instr", o_instr, 0);
      chk("rst_pc", o_pc, 0);
      chk("rst_fault", o_acc_fault, 0);
      rel();
      chk("t1_first_arvalid", o_ifu_arvalid, 1);
      chk("t1_first_araddr", o_ifu_araddr, RST_PC);
      run(18);
      chk("t1_nar", ar_q.size(), 6);
      chk("t1_npop", pop_pc_q.size(), 6);
      chk("t1_ar0", ar_q[0], 32'h8000_0000);
      chk("t1_ar1", ar_q[1], 32'h8000_0004);
      chk("t1_ar2", ar_q[2], 32'h8000_0008);
      for (int i = 0; i < pop_pc_q.size(); i++) begin
         chk($sformatf("t1_pc%0d", i), pop_pc_q[i], RST_PC + 32'(4 * i));
         chk($sformatf("t1_ins%0d", i), pop_ins_q[i], (RST_PC + 32'(4 * i)) ^ XMASK);
      end

      // Backpressure: two requests fill the buffer, then fetch stalls
      do_reset();
      i_post_ready = 1'b0;
      rel();
      run(10);
      chk("t2_nar", ar_q.size(), 2);
      chk("t2_arvalid", o_ifu_arvalid, 0);
      chk("t2_pvalid", o_post_valid, 1);
      chk("t2_pc", o_pc, 32'h8000_0000);
      chk("t2_ins", o_instr, 32'h25A5_0000);
      i_post_ready = 1'b1;
      cyc();
      i_post_ready = 1'b0;
      chk("t2_npop", pop_pc_q.size(), 1);
      chk("t2_pop_pc", pop_pc_q[0], 32'h8000_0000);
      chk("t2_head_pc", o_pc, 32'h8000_0004);
      run(2);
      chk("t2_nar3", ar_q.size(), 3);
      chk("t2_ar2", ar_q[2], 32'h8000_0008);

      // Redirect while waiting for data, with a buffered entry present
      do_reset();
      i_post_ready = 1'b0; lat = 2;
      rel();
      run(5);
      chk("t3_rready", o_ifu_rready, 1);
      chk("t3_pre_pvalid", o_post_valid, 1);
      i_redirect = 1'b1; i_redirect_pc = 32'h8000_1002;
      #1;
      chk("t3_gate_pvalid", o_post_valid, 0);
      cyc();
      i_redirect = 1'b0;
      chk("t3_flush_pvalid", o_post_valid, 0);
      chk("t3_hold_pc", o_pc, 32'h8000_0000);
      i_post_ready = 1'b1;
      run(6);
      chk("t3_nar", ar_q.size(), 3);
      chk("t3_ar_redir", ar_q[2], 32'h8000_1000);
      chk("t3_npop", pop_pc_q.size(), 1);
      chk("t3_pop_pc", pop_pc_q[0], 32'h8000_1000);
      chk("t3_pop_ins", pop_ins_q[0], 32'h25A5_1000);

      // Redirect while the address channel is stalled
      do_reset();
      lat = 1; i_post_ready = 1'b1; i_ifu_arready = 1'b0;
      rel();
      cyc();
      i_redirect = 1'b1; i_redirect_pc = 32'h8000_2000;
      cyc();
      i_redirect = 1'b0;
      chk("t4_arvalid", o_ifu_arvalid, 1);
      chk("t4_araddr_a", o_ifu_araddr, 32'h8000_0000);
      run(2);
      chk("t4_araddr_b", o_ifu_araddr, 32'h8000_0000);
      cyc();
      i_ifu_arready = 1'b1;
      run(6);
      chk("t4_nar", ar_q.size(), 2);
      chk("t4_ar0", ar_q[0], 32'h8000_0000);
      chk("t4_ar1", ar_q[1], 32'h8000_2000);
      chk("t4_npop", pop_pc_q.size(), 1);
      chk("t4_pop_pc", pop_pc_q[0], 32'h8000_2000);

      // Error response becomes a faulting, zeroed entry
      do_reset();
      err_addr = 32'h8000_0004;
      rel();
      run(12);
      chk("t5_npop", pop_pc_q.size(), 4);
      chk("t5_flt0", pop_flt_q[0], 0);
      chk("t5_pc1", pop_pc_q[1], 32'h8000_0004);
      chk("t5_flt1", pop_flt_q[1], 1);
      chk("t5_ins1", pop_ins_q[1], 0);
      chk("t5_pc2", pop_pc_q[2], 32'h8000_0008);
      chk("t5_flt2", pop_flt_q[2], 0);
      chk("t5_ins2", pop_ins_q[2], 32'h25A5_0008);
      err_addr = 32'hFFFF_FFFF;

      // Reset during WAIT with a stale beat arriving afterwards
      do_reset();
      lat = 2; i_post_ready = 1'b0;
      rel();
      cyc();
      chk("t6_rready", o_ifu_rready, 1);
      i_rst = 1'b1;
      cyc();
      i_rst = 1'b0;
      ar_q.delete();
      chk("t6_stale_seen", i_ifu_rvalid, 1);
      chk("t6_pvalid_a", o_post_valid, 0);
      chk("t6_arvalid_a", o_ifu_arvalid, 0);
      chk("t6_pc0", o_pc, 0);
      cyc();
      i_ifu_rvalid = 1'b0;
      chk("t6_arvalid_b", o_ifu_arvalid, 1);
      chk("t6_araddr", o_ifu_araddr, RST_PC);
      chk("t6_pvalid_b", o_post_valid, 0);
      cyc();
      chk("t6_pvalid_c", o_post_valid, 0);
      cyc();
      chk("t6_pvalid_d", o_post_valid, 0);
      cyc();
      chk("t6_pvalid_e", o_post_valid, 1);
      chk("t6_pc", o_pc, RST_PC);
      chk("t6_ins", o_instr, 32'h25A5_0000);
      chk("t6_nar", ar_q.size(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
